// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider with valid/ready handshake.
// One quotient bit per cycle, WIDTH cycles per operation, result held until consumed.
//
// state | meaning
// IDLE  | waiting for an operand pair
// BUSY  | iterating, one quotient bit per edge
// DONE  | result valid, waiting for out_ready
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_src1,
   input  logic [WIDTH-1:0] div_src2,
   input  logic             cancel,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              accept;
   logic [CNT_W-1:0]  counter;
   logic [WIDTH-1:0]  rem_q;
   logic [WIDTH-1:0]  dvd_q;
   logic [WIDTH-1:0]  dvsr_q;
   logic [WIDTH-1:0]  raw1_q;
   logic              sign1_q, sign2_q, dz_q;

   logic [WIDTH:0]    shifted;
   logic [WIDTH-1:0]  diff;
   logic              ge;
   logic [WIDTH-1:0]  next_rem, next_dvd;
   logic [WIDTH-1:0]  fix_q, fix_r;
   logic [WIDTH-1:0]  abs1, abs2;

   // Handshake, status outputs and next-state selection; cancel overrides everything.
   always_comb begin
      state_d   = state_q;
      busy      = (state_q == BUSY);
      out_valid = (state_q == DONE);
      div_ready = !cancel && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
      accept    = div_valid && div_ready;
      if (cancel) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (counter == LAST_CNT) state_d = DONE;
            DONE: begin
               if (accept)         state_d = BUSY;
               else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // One restoring step plus final sign fix-up, computed from the current working registers.
   always_comb begin
      abs1     = (div_signed && div_src1[WIDTH-1]) ? -div_src1 : div_src1;
      abs2     = (div_signed && div_src2[WIDTH-1]) ? -div_src2 : div_src2;
      shifted  = {rem_q, dvd_q[WIDTH-1]};
      ge       = (shifted >= {1'b0, dvsr_q});
      diff     = shifted[WIDTH-1:0] - dvsr_q;
      next_rem = ge ? diff : shifted[WIDTH-1:0];
      next_dvd = {dvd_q[WIDTH-2:0], ge};
      fix_q    = (sign1_q ^ sign2_q) ? -next_dvd : next_dvd;
      fix_r    = sign1_q ? -next_rem : next_rem;
      if (dz_q) begin
         fix_q = '1;
         fix_r = raw1_q;
      end
   end

   // Operand latch, iteration datapath and result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         counter   <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvsr_q    <= '0;
         raw1_q    <= '0;
         sign1_q   <= 1'b0;
         sign2_q   <= 1'b0;
         dz_q      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (cancel) begin
         counter <= '0;
      end else if (accept) begin
         counter <= '0;
         rem_q   <= '0;
         dvd_q   <= abs1;
         dvsr_q  <= abs2;
         raw1_q  <= div_src1;
         sign1_q <= div_signed && div_src1[WIDTH-1];
         sign2_q <= div_signed && div_src2[WIDTH-1];
         dz_q    <= (div_src2 == '0);
      end else if (state_q == BUSY) begin
         counter <= counter + CNT_W'(1);
         rem_q   <= next_rem;
         dvd_q   <= next_dvd;
         if (counter == LAST_CNT) begin
            quotient  <= fix_q;
            remainder <= fix_r;
         end
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table plus hand sequences for
// backpressure, back-to-back accept, cancel and asynchronous reset.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        div_valid, div_ready, div_signed;
   logic [31:0] div_src1, div_src2;
   logic        cancel, busy, out_valid, out_ready;
   logic [31:0] quotient, remainder;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[10];

   div_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .div_valid(div_valid), .div_ready(div_ready), .div_signed(div_signed),
      .div_src1(div_src1), .div_src2(div_src2),
      .cancel(cancel), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present an operand pair at a negedge; returns at the negedge after the accept edge.
   task automatic start(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      div_src1 = a; div_src2 = b; div_signed = s; div_valid = 1'b1;
      #1 check({name, " div_ready"}, 32'(div_ready), 32'd1);
      @(negedge clk);
      div_valid = 1'b0;
      div_src1 = 32'hDEAD_BEEF; div_src2 = 32'h0000_0001; div_signed = ~s;
   endtask

   // Count edges from the accept edge until out_valid rises; busy must be high throughout.
   task automatic wait_done(input string name);
      int n = 0;
      int busy_cnt = 0;
      while (!out_valid && n < 100) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      check({name, " latency"}, 32'(n), 32'd32);
      check({name, " busy cycles"}, 32'(busy_cnt), 32'd32);
   endtask

   task automatic consume(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] q, input logic [31:0] r);
      start(name, a, b, s);
      wait_done(name);
      check({name, " quotient"}, quotient, q);
      check({name, " remainder"}, remainder, r);
      consume(name);
   endtask

   initial begin
      vecs[0] = '{"u100/7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
      vecs[1] = '{"s-7/2",      32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2] = '{"s7/-2",      32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
      vecs[3] = '{"s-7/-2",     32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF};
      vecs[4] = '{"u-7/2",      32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
      vecs[5] = '{"s_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
      vecs[6] = '{"u_dz",       32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234};
      vecs[7] = '{"s_dz",       32'h0000_1234,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h0000_1234};
      vecs[8] = '{"u_max/max",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0};
      vecs[9] = '{"u5/10",      32'd5,          32'd10,         1'b0, 32'd0,          32'd5};

      reset = 1'b1; div_valid = 1'b0; div_signed = 1'b0; div_src1 = '0; div_src2 = '0;
      cancel = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle div_ready", 32'(div_ready), 32'd1);

      foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r);

      // Backpressure then back-to-back accept with no bubble.
      start("bp", 32'd1000, 32'd3, 1'b0);
      wait_done("bp");
      for (int i = 0; i < 10; i++) begin
         check("bp hold quotient", quotient, 32'd333);
         check("bp hold remainder", remainder, 32'd1);
         check("bp hold out_valid", 32'(out_valid), 32'd1);
         check("bp div_ready low", 32'(div_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1; div_valid = 1'b1; div_src1 = 32'd50; div_src2 = 32'd5; div_signed = 1'b0;
      #1 check("b2b div_ready", 32'(div_ready), 32'd1);
      @(negedge clk);
      out_ready = 1'b0; div_valid = 1'b0; div_src1 = 32'd77; div_src2 = 32'd0;
      check("b2b busy", 32'(busy), 32'd1);
      check("b2b out_valid", 32'(out_valid), 32'd0);
      wait_done("b2b");
      check("b2b quotient", quotient, 32'd10);
      check("b2b remainder", remainder, 32'd0);
      consume("b2b");

      // Cancel mid-iteration.
      start("cancel", 32'd1000, 32'd7, 1'b0);
      repeat (15) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      check("cancel busy", 32'(busy), 32'd0);
      check("cancel out_valid", 32'(out_valid), 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
         end
         check("cancel no result", 32'(seen), 32'd0);
      end
      run_op("9/4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1);

      // Cancel together with div_valid in IDLE: no accept.
      div_valid = 1'b1; cancel = 1'b1; div_src1 = 32'd8; div_src2 = 32'd2;
      #1 check("cancel+valid ready", 32'(div_ready), 32'd0);
      @(negedge clk);
      div_valid = 1'b0; cancel = 1'b0;
      check("cancel+valid busy", 32'(busy), 32'd0);

      // Asynchronous reset between edges during BUSY.
      start("rst", 32'd1000, 32'd7, 1'b0);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async busy", 32'(busy), 32'd0);
      check("async out_valid", 32'(out_valid), 32'd0);
      check("async quotient", quotient, 32'd0);
      check("async remainder", remainder, 32'd0);
      reset = 1'b0;
      run_op("20/3", 32'd20, 32'd3, 1'b0, 32'd6, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
